// File: rtl/sap_control_sequencer.sv
// SAP CPU control sequencer: T-state counter plus opcode decode that drives the
// datapath control word. Controls are combinational from step/opcode/flags/halted.
module sap_control_sequencer #(
  parameter bit EARLY_END = 1'b1
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [3:0] opcode,
  input  logic       carry_flag,
  input  logic       zero_flag,
  output logic       hlt,
  output logic       mar_ld_n,
  output logic       ram_we,
  output logic       ram_oe_n,
  output logic       ir_ld_n,
  output logic       ir_oe_n,
  output logic       a_ld_n,
  output logic       a_oe_n,
  output logic       b_ld_n,
  output logic       alu_oe_n,
  output logic       alu_sub,
  output logic       out_ld_n,
  output logic       pc_inc,
  output logic       pc_oe_n,
  output logic       pc_ld,
  output logic       flags_ld,
  output logic [2:0] step
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_t;

  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  step_t step_q;
  logic  halted;
  step_t last_step;

  assign step = step_q;

  always_comb begin
    last_step = T2;
    case (opcode)
      OP_LDA, OP_STA: last_step = T3;
      OP_ADD, OP_SUB: last_step = T4;
      default:        last_step = T2;
    endcase
  end

  // Halting freezes the counter at T2; only clr_n brings the sequencer back.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      step_q <= T0;
      halted <= 1'b0;
    end else if (!halted) begin
      if (step_q == T2 && opcode == OP_HLT) begin
        halted <= 1'b1;
      end else if (EARLY_END && step_q == last_step) begin
        step_q <= T0;
      end else if (step_q >= T4) begin
        step_q <= T0;
      end else begin
        step_q <= step_t'(step_q + 3'd1);
      end
    end
  end

  always_comb begin
    hlt      = 1'b0;
    mar_ld_n = 1'b1;
    ram_we   = 1'b0;
    ram_oe_n = 1'b1;
    ir_ld_n  = 1'b1;
    ir_oe_n  = 1'b1;
    a_ld_n   = 1'b1;
    a_oe_n   = 1'b1;
    b_ld_n   = 1'b1;
    alu_oe_n = 1'b1;
    alu_sub  = 1'b0;
    out_ld_n = 1'b1;
    pc_inc   = 1'b0;
    pc_oe_n  = 1'b1;
    pc_ld    = 1'b0;
    flags_ld = 1'b0;
    if (clr_n) begin
      if (halted) begin
        hlt = 1'b1;
      end else begin
        case (step_q)
          T0: begin
            pc_oe_n  = 1'b0;
            mar_ld_n = 1'b0;
          end
          T1: begin
            ram_oe_n = 1'b0;
            ir_ld_n  = 1'b0;
            pc_inc   = 1'b1;
          end
          T2: begin
            case (opcode)
              OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                ir_oe_n  = 1'b0;
                mar_ld_n = 1'b0;
              end
              OP_LDI: begin
                ir_oe_n = 1'b0;
                a_ld_n  = 1'b0;
              end
              OP_JMP: begin
                ir_oe_n = 1'b0;
                pc_ld   = 1'b1;
              end
              OP_JC: begin
                ir_oe_n = ~carry_flag;
                pc_ld   = carry_flag;
              end
              OP_JZ: begin
                ir_oe_n = ~zero_flag;
                pc_ld   = zero_flag;
              end
              OP_OUT: begin
                a_oe_n   = 1'b0;
                out_ld_n = 1'b0;
              end
              OP_HLT: hlt = 1'b1;
              default: ;
            endcase
          end
          T3: begin
            case (opcode)
              OP_LDA: begin
                ram_oe_n = 1'b0;
                a_ld_n   = 1'b0;
              end
              OP_ADD, OP_SUB: begin
                ram_oe_n = 1'b0;
                b_ld_n   = 1'b0;
              end
              OP_STA: begin
                a_oe_n = 1'b0;
                ram_we = 1'b1;
              end
              default: ;
            endcase
          end
          T4: begin
            if (opcode == OP_ADD || opcode == OP_SUB) begin
              alu_oe_n = 1'b0;
              a_ld_n   = 1'b0;
              flags_ld = 1'b1;
              alu_sub  = (opcode == OP_SUB);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed bench for sap_control_sequencer: one instance per EARLY_END setting,
// control word packed into a vector and compared against hand-built constants.
module tb_sap_control_sequencer;

  logic       clk;
  logic       clr_n;
  logic [3:0] opcode_e, opcode_f;
  logic       carry_flag, zero_flag;

  logic hlt_e, mar_e, we_e, ramoe_e, irld_e, iroe_e, ald_e, aoe_e, bld_e;
  logic aluoe_e, sub_e, outld_e, pcinc_e, pcoe_e, pcld_e, flags_e;
  logic hlt_f, mar_f, we_f, ramoe_f, irld_f, iroe_f, ald_f, aoe_f, bld_f;
  logic aluoe_f, sub_f, outld_f, pcinc_f, pcoe_f, pcld_f, flags_f;
  logic [2:0] step_e, step_f;
  logic [15:0] cw_e, cw_f;

  int checks = 0;
  int fails  = 0;

  localparam logic [15:0] M_HLT   = 16'h8000;
  localparam logic [15:0] M_MAR   = 16'h4000;
  localparam logic [15:0] M_WE    = 16'h2000;
  localparam logic [15:0] M_RAMOE = 16'h1000;
  localparam logic [15:0] M_IRLD  = 16'h0800;
  localparam logic [15:0] M_IROE  = 16'h0400;
  localparam logic [15:0] M_ALD   = 16'h0200;
  localparam logic [15:0] M_AOE   = 16'h0100;
  localparam logic [15:0] M_BLD   = 16'h0080;
  localparam logic [15:0] M_ALUOE = 16'h0040;
  localparam logic [15:0] M_SUB   = 16'h0020;
  localparam logic [15:0] M_OUTLD = 16'h0010;
  localparam logic [15:0] M_PCINC = 16'h0008;
  localparam logic [15:0] M_PCOE  = 16'h0004;
  localparam logic [15:0] M_PCLD  = 16'h0002;
  localparam logic [15:0] M_FLAGS = 16'h0001;

  // Active-low lines idle at 1, active-high lines idle at 0; flipping a mask bit activates it.
  localparam logic [15:0] INACT   = 16'b0101_1111_1101_0100;
  localparam logic [15:0] CW_T0   = INACT ^ (M_PCOE | M_MAR);
  localparam logic [15:0] CW_T1   = INACT ^ (M_RAMOE | M_IRLD | M_PCINC);
  localparam logic [15:0] CW_ADR  = INACT ^ (M_IROE | M_MAR);
  localparam logic [15:0] CW_LDA3 = INACT ^ (M_RAMOE | M_ALD);
  localparam logic [15:0] CW_ADD3 = INACT ^ (M_RAMOE | M_BLD);
  localparam logic [15:0] CW_ADD4 = INACT ^ (M_ALUOE | M_ALD | M_FLAGS);
  localparam logic [15:0] CW_SUB4 = CW_ADD4 ^ M_SUB;
  localparam logic [15:0] CW_STA3 = INACT ^ (M_AOE | M_WE);
  localparam logic [15:0] CW_LDI  = INACT ^ (M_IROE | M_ALD);
  localparam logic [15:0] CW_JMP  = INACT ^ (M_IROE | M_PCLD);
  localparam logic [15:0] CW_OUT  = INACT ^ (M_AOE | M_OUTLD);
  localparam logic [15:0] CW_HLT  = INACT ^ M_HLT;

  assign cw_e = {hlt_e, mar_e, we_e, ramoe_e, irld_e, iroe_e, ald_e, aoe_e,
                 bld_e, aluoe_e, sub_e, outld_e, pcinc_e, pcoe_e, pcld_e, flags_e};
  assign cw_f = {hlt_f, mar_f, we_f, ramoe_f, irld_f, iroe_f, ald_f, aoe_f,
                 bld_f, aluoe_f, sub_f, outld_f, pcinc_f, pcoe_f, pcld_f, flags_f};

  sap_control_sequencer #(.EARLY_END(1'b1)) dut_e (
    .clk(clk), .clr_n(clr_n), .opcode(opcode_e),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .hlt(hlt_e), .mar_ld_n(mar_e), .ram_we(we_e), .ram_oe_n(ramoe_e),
    .ir_ld_n(irld_e), .ir_oe_n(iroe_e), .a_ld_n(ald_e), .a_oe_n(aoe_e),
    .b_ld_n(bld_e), .alu_oe_n(aluoe_e), .alu_sub(sub_e), .out_ld_n(outld_e),
    .pc_inc(pcinc_e), .pc_oe_n(pcoe_e), .pc_ld(pcld_e), .flags_ld(flags_e),
    .step(step_e)
  );

  sap_control_sequencer #(.EARLY_END(1'b0)) dut_f (
    .clk(clk), .clr_n(clr_n), .opcode(opcode_f),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .hlt(hlt_f), .mar_ld_n(mar_f), .ram_we(we_f), .ram_oe_n(ramoe_f),
    .ir_ld_n(irld_f), .ir_oe_n(iroe_f), .a_ld_n(ald_f), .a_oe_n(aoe_f),
    .b_ld_n(bld_f), .alu_oe_n(aluoe_f), .alu_sub(sub_f), .out_ld_n(outld_f),
    .pc_inc(pcinc_f), .pc_oe_n(pcoe_f), .pc_ld(pcld_f), .flags_ld(flags_f),
    .step(step_f)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [3:0] op_e, input logic [3:0] op_f,
                               input logic c, input logic z);
    opcode_e   = op_e;
    opcode_f   = op_f;
    carry_flag = c;
    zero_flag  = z;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] cw_obs,
                             input logic [2:0] st_obs, input logic [15:0] cw_exp,
                             input logic [2:0] st_exp);
    checks++;
    assert ({cw_obs, st_obs} === {cw_exp, st_exp})
    else begin
      fails++;
      $error("[TB] FAIL %s: observed cw=%h step=%0d, expected cw=%h step=%0d",
             tag, cw_obs, st_obs, cw_exp, st_exp);
    end
  endtask

  // Outputs settle 1 time unit after any input change before being compared.
  task automatic chkE(input string tag, input logic [15:0] cw_exp, input logic [2:0] st_exp);
    #1;
    checkOutput(tag, cw_e, step_e, cw_exp, st_exp);
  endtask

  task automatic chkF(input string tag, input logic [15:0] cw_exp, input logic [2:0] st_exp);
    #1;
    checkOutput(tag, cw_f, step_f, cw_exp, st_exp);
  endtask

  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    clr_n = 1'b0;
    #3;
    clr_n = 1'b1;
  endtask

  initial begin
    clr_n = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    chkE("reset_e", INACT, 3'd0);
    chkF("reset_f", INACT, 3'd0);
    clr_n = 1'b1;
    chkE("release_t0", CW_T0, 3'd0);

    // LDA aborted by a 3 ns reset pulse in T3
    applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0);
    cycle(); chkE("lda_t1", CW_T1, 3'd1);
    cycle(); chkE("lda_t2", CW_ADR, 3'd2);
    cycle(); chkE("lda_t3", CW_LDA3, 3'd3);
    clr_n = 1'b0;
    chkE("lda_abort", INACT, 3'd0);
    #2;
    clr_n = 1'b1;
    chkE("abort_rel_t0", CW_T0, 3'd0);
    cycle(); chkE("abort_t1", CW_T1, 3'd1);
    cycle(); chkE("abort_t2", CW_ADR, 3'd2);

    // Program LDI, ADD, OUT, HLT with early end
    doReset();
    applyStimulus(4'b0101, 4'b0000, 1'b0, 1'b0);
    chkE("ldi_t0", CW_T0, 3'd0);
    cycle(); chkE("ldi_t1", CW_T1, 3'd1);
    applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0);
    chkE("t1_op_ignored", CW_T1, 3'd1);
    applyStimulus(4'b0101, 4'b0000, 1'b0, 1'b0);
    cycle(); chkE("ldi_t2", CW_LDI, 3'd2);
    cycle(); chkE("ldi_end", CW_T0, 3'd0);
    applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0);
    cycle(); chkE("add_t1", CW_T1, 3'd1);
    cycle(); chkE("add_t2", CW_ADR, 3'd2);
    cycle(); chkE("add_t3", CW_ADD3, 3'd3);
    cycle(); chkE("add_t4", CW_ADD4, 3'd4);
    cycle(); chkE("add_end", CW_T0, 3'd0);
    applyStimulus(4'b1110, 4'b0000, 1'b0, 1'b0);
    cycle(); chkE("out_t1", CW_T1, 3'd1);
    cycle(); chkE("out_t2", CW_OUT, 3'd2);
    cycle(); chkE("out_end", CW_T0, 3'd0);
    applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0);
    cycle(); chkE("hlt_t1", CW_T1, 3'd1);
    cycle(); chkE("hlt_t2", CW_HLT, 3'd2);
    cycle(); chkE("halted_1", CW_HLT, 3'd2);
    applyStimulus(4'b0101, 4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) cycle();
    chkE("halted_10", CW_HLT, 3'd2);
    clr_n = 1'b0;
    chkE("halt_clear", INACT, 3'd0);
    #2;
    clr_n = 1'b1;
    chkE("halt_rel_t0", CW_T0, 3'd0);

    // STA with early end
    doReset();
    applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b0);
    cycle(); cycle(); chkE("sta_t2", CW_ADR, 3'd2);
    cycle(); chkE("sta_t3", CW_STA3, 3'd3);
    cycle(); chkE("sta_end", CW_T0, 3'd0);

    // SUB on the fixed five-step instance
    doReset();
    applyStimulus(4'b0000, 4'b0011, 1'b0, 1'b0);
    chkF("sub_t0", CW_T0, 3'd0);
    cycle(); chkF("sub_t1", CW_T1, 3'd1);
    cycle(); chkF("sub_t2", CW_ADR, 3'd2);
    cycle(); chkF("sub_t3", CW_ADD3, 3'd3);
    cycle(); chkF("sub_t4", CW_SUB4, 3'd4);
    cycle(); chkF("sub_wrap", CW_T0, 3'd0);

    // Conditional jumps follow the flags combinationally in T2
    doReset();
    applyStimulus(4'b0111, 4'b0000, 1'b0, 1'b1);
    cycle(); cycle(); chkE("jc_c0", INACT, 3'd2);
    applyStimulus(4'b0111, 4'b0000, 1'b1, 1'b1);
    chkE("jc_c1", CW_JMP, 3'd2);
    cycle(); chkE("jc_end", CW_T0, 3'd0);
    applyStimulus(4'b1000, 4'b0000, 1'b1, 1'b0);
    cycle(); cycle(); chkE("jz_z0", INACT, 3'd2);
    applyStimulus(4'b1000, 4'b0000, 1'b1, 1'b1);
    chkE("jz_z1", CW_JMP, 3'd2);
    cycle(); chkE("jz_end", CW_T0, 3'd0);
    applyStimulus(4'b0110, 4'b0000, 1'b0, 1'b0);
    cycle(); cycle(); chkE("jmp_t2", CW_JMP, 3'd2);

    // Undefined opcode 1010 on both instances
    doReset();
    applyStimulus(4'b1010, 4'b1010, 1'b1, 1'b1);
    cycle(); chkE("undef_e_t1", CW_T1, 3'd1);
    chkF("undef_f_t1", CW_T1, 3'd1);
    cycle(); chkE("undef_e_t2", INACT, 3'd2);
    chkF("undef_f_t2", INACT, 3'd2);
    cycle(); chkE("undef_e_end", CW_T0, 3'd0);
    chkF("undef_f_t3", INACT, 3'd3);
    cycle(); chkF("undef_f_t4", INACT, 3'd4);
    cycle(); chkF("undef_f_end", CW_T0, 3'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/sap_control_sequencer.md
# sap_control_sequencer

Microcoded control sequencer for the SAP CPU: a step counter plus opcode decode that produces the control word for the datapath registers. It sits directly upstream of every quad-flip-flop register. It drives those registers' active-low load gates and active-low output enables, and it drives the PC, RAM, ALU and flags control lines. It consumes the opcode nibble held in the instruction register and the carry/zero bits held in the flags register.

## Interface
- EARLY_END, default 1: 1 = return to T0 right after an instruction's last active step; 0 = fixed 5-step cycle (T0..T4).
- clk  in  1  system clock; all state changes on rising edge.
- clr_n  in  1  asynchronous, active-low reset.
- opcode  in  4  upper nibble of the instruction register; valid from T2 onward.
- carry_flag  in  1  registered carry flag.
- zero_flag  in  1  registered zero flag.
- hlt  out  1  halt indicator (active high).
- mar_ld_n  out  1  MAR load gate (low = load).
- ram_we  out  1  RAM write strobe.
- ram_oe_n  out  1  RAM drives bus.
- ir_ld_n  out  1  IR load.
- ir_oe_n  out  1  IR low nibble drives bus.
- a_ld_n  out  1  A register load.
- a_oe_n  out  1  A drives bus.
- b_ld_n  out  1  B register load.
- alu_oe_n  out  1  ALU drives bus.
- alu_sub  out  1  ALU subtract select.
- out_ld_n  out  1  output register load.
- pc_inc  out  1  PC increment.
- pc_oe_n  out  1  PC drives bus.
- pc_ld  out  1  PC load from bus (jump).
- flags_ld  out  1  flags register load.
- step  out  3  current T-state, 0..4 (debug).

## Operation
- State: a 3-bit step counter (T0..T4) and a halted bit.
- Control outputs are combinational from step, opcode, flags and halted. They are valid for the whole cycle and are consumed at the next rising edge.
- Inactive values: every *_n output is 1; every active-high output is 0.
- Fetch, independent of opcode:
  - T0: pc_oe_n=0, mar_ld_n=0.
  - T1: ram_oe_n=0, ir_ld_n=0, pc_inc=1.
- Execute, by opcode:
  - 0001 LDA: T2 ir_oe_n, mar_ld_n; T3 ram_oe_n, a_ld_n.
  - 0010 ADD: T2 ir_oe_n, mar_ld_n; T3 ram_oe_n, b_ld_n; T4 alu_oe_n, a_ld_n, flags_ld.
  - 0011 SUB: same as ADD, with alu_sub=1 during T4 only.
  - 0100 STA: T2 ir_oe_n, mar_ld_n; T3 a_oe_n, ram_we.
  - 0101 LDI: T2 ir_oe_n, a_ld_n.
  - 0110 JMP: T2 ir_oe_n, pc_ld.
  - 0111 JC: T2 ir_oe_n, pc_ld only if carry_flag=1; otherwise T2 is empty.
  - 1000 JZ: as JC, conditioned on zero_flag.
  - 1110 OUT: T2 a_oe_n, out_ld_n.
  - 1111 HLT: T2 hlt=1.
  - 0000 and all undefined opcodes: T2..T4 empty (NOP).
- Steps not listed for an opcode are empty.
- Last active step per opcode: LDA/STA = T3; ADD/SUB = T4; LDI/JMP/JC/JZ/OUT/NOP/undefined = T2.
- Counter advance:
  - EARLY_END=1: next step is T0 after the last active step, otherwise step+1.
  - EARLY_END=0: T4 -> T0, otherwise step+1.
- Halt:
  - At the rising edge ending HLT's T2, halted is set to 1.
  - While halted: step stays at 2, hlt=1, every other control is inactive, and opcode and flags are ignored.
  - Only clr_n leaves halt.
- At most one bus driver is active in any step; the decode guarantees this.

## Timing
- Reset (clr_n=0), asynchronous: step=0, halted=0, and every control output is forced inactive combinationally while clr_n=0 (including hlt=0).
- Release: the first rising edge with clr_n=1 samples T0 controls. T0 controls are visible as soon as clr_n rises.
- Reset asserted mid-instruction aborts it immediately; there is no partial-step completion.
- Instruction length with EARLY_END=1: LDI/JMP/JC/JZ/OUT/NOP = 3 clocks, LDA/STA = 4, ADD/SUB = 5.
- With EARLY_END=0, every instruction takes 5 clocks.
- Conditional jumps sample carry_flag/zero_flag combinationally during T2. A flags change within T2 is followed combinationally.
- Changes to opcode during T0/T1 have no effect on any output.

## Test plan
- Reset mid-T3 of LDA (clr_n low for 3 ns between edges) -> all controls inactive immediately, step=0; after release, the next two edges execute a T0 fetch then a T1 fetch.
- Program LDI 5, ADD, OUT, HLT with EARLY_END=1 -> step sequences 0,1,2 / 0,1,2,3,4 / 0,1,2 / 0,1,2. In ADD T4: alu_oe_n=0, a_ld_n=0, flags_ld=1, alu_sub=0.
- SUB with EARLY_END=0 -> alu_sub=1 only in T4, and the step wraps 4->0.
- JC at T2 with carry_flag=0 -> all controls inactive and the next step is 0. With carry_flag=1 -> ir_oe_n=0, pc_ld=1. Repeat for JZ with zero_flag.
- HLT -> hlt=1 at T2. After 10 further clocks: step=2, hlt=1, all other controls inactive, even with opcode changed to 0101. After pulsing clr_n low: hlt=0, step=0.
- Undefined opcode 1010 under each EARLY_END value -> no control active in T2..T4. Step sequence is 0,1,2,0 (EARLY_END=1) or 0..4,0 (EARLY_END=0).
